pulse_gen: RTL and testbench

Parametrised periodic strobe generator, the successor to the fixed-count keyboard scan tick.
- Produces a registered pulse of programmable period and high-width.
- Supports continuous and one-shot modes.
- Adds a single-cycle rising-edge tick and shadowed, glitch-free reprogramming.
- Sits beside wishbone peripherals (keyboard scan, debounce, display refresh) as their timebase.

---
 rtl/pulse_gen_if.sv | 25 ++
 rtl/pulse_gen.sv | 133 +++++++++++++
 tb/tb_pulse_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_if.sv
// Control/status bundle for pulse_gen: run control and programming inputs,
// strobe and status outputs.
interface pulse_gen_if #(
    parameter int unsigned CNT_W = 30
);
    logic             en;
    logic             mode;
    logic             start;
    logic             load;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] width_in;
    logic             pulse;
    logic             tick;
    logic             busy;

    modport master (
        output en, mode, start, load, period_in, width_in,
        input  pulse, tick, busy
    );

    modport slave (
        input  en, mode, start, load, period_in, width_in,
        output pulse, tick, busy
    );
endinterface

// File: rtl/pulse_gen.sv
// Periodic/one-shot strobe generator with shadowed period/width programming.
// Optional clock prescaler enabled by defining PULSE_GEN_PRESCALE_EN.
module pulse_gen #(
    parameter int unsigned CNT_W      = 30,
    parameter int unsigned DEF_PERIOD = 62500,
    parameter int unsigned DEF_WIDTH  = 3
`ifdef PULSE_GEN_PRESCALE_EN
    ,
    parameter int unsigned PRESC      = 1
`endif
) (
    input logic        clk,
    input logic        rst_n,
    pulse_gen_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEF_WIDTH);

    function automatic logic [CNT_W-1:0] eff_p(input logic [CNT_W-1:0] p);
        return (p < TWO) ? TWO : p;
    endfunction

    function automatic logic [CNT_W-1:0] eff_w(input logic [CNT_W-1:0] p,
                                               input logic [CNT_W-1:0] w);
        logic [CNT_W-1:0] pm1;
        pm1 = eff_p(p) - ONE;
        return (w > pm1) ? pm1 : w;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] sh_p, sh_w;
    logic [CNT_W-1:0] act_p, act_w;
    logic [CNT_W-1:0] cnt;
    logic             pulse_r, tick_r, busy_r;

    logic [CNT_W-1:0] nxt_p, nxt_w;
    logic [CNT_W-1:0] idle_p, idle_w, wrap_p, wrap_w;
    logic [CNT_W-1:0] thr;
    logic             cmp, wrap, adv;

`ifdef PULSE_GEN_PRESCALE_EN
    localparam int unsigned      PS_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESC - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);

    logic [PS_W-1:0] ps;

    assign adv = (ps == PS_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.en || state != RUN) begin
            ps <= '0;
        end else if (adv) begin
            ps <= '0;
        end else begin
            ps <= ps + PS_ONE;
        end
    end
`else
    assign adv = 1'b1;
`endif

    // While idle the active set follows the shadow's next value, so a load
    // coinciding with start/en is already in force for that run.
    always_comb begin
        nxt_p  = bus.load ? bus.period_in : sh_p;
        nxt_w  = bus.load ? bus.width_in  : sh_w;
        idle_p = eff_p(nxt_p);
        idle_w = eff_w(nxt_p, nxt_w);
        wrap_p = eff_p(sh_p);
        wrap_w = eff_w(sh_p, sh_w);
        thr    = act_p - act_w;
        cmp    = (cnt >= thr);
        wrap   = adv && (cnt == act_p - ONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh_p    <= DEF_P;
            sh_w    <= DEF_W;
            act_p   <= eff_p(DEF_P);
            act_w   <= eff_w(DEF_P, DEF_W);
            cnt     <= '0;
            pulse_r <= 1'b0;
            tick_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (bus.load) begin
                sh_p <= bus.period_in;
                sh_w <= bus.width_in;
            end
            if (!bus.en || state == IDLE) begin
                act_p   <= idle_p;
                act_w   <= idle_w;
                cnt     <= '0;
                pulse_r <= 1'b0;
                tick_r  <= 1'b0;
                if (bus.en && (!bus.mode || bus.start)) begin
                    state  <= RUN;
                    busy_r <= 1'b1;
                end else begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            end else begin
                pulse_r <= cmp;
                tick_r  <= cmp && !pulse_r;
                // Mode is sampled at the wrap: one-shot ends the run here and
                // the trailing pulse cycle is cleared by the idle branch.
                if (wrap) begin
                    cnt   <= '0;
                    act_p <= wrap_p;
                    act_w <= wrap_w;
                    if (bus.mode) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end else if (adv) begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

    assign bus.pulse = pulse_r;
    assign bus.tick  = tick_r;
    assign bus.busy  = busy_r;
endmodule

// File: tb/tb_pulse_gen.sv
// Vector-table bench for pulse_gen (CNT_W=30, defaults 7/3): per-cycle
// expected {pulse,tick,busy} go through a scoreboard queue.
module tb_pulse_gen;
    logic clk;
    logic rst_n;

    pulse_gen_if #(.CNT_W(30)) bus ();

    pulse_gen #(
        .CNT_W      (30),
        .DEF_PERIOD (7),
        .DEF_WIDTH  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        mode;
        logic        start;
        logic        load;
        logic [29:0] p;
        logic [29:0] w;
        logic [2:0]  exp;   // {pulse, tick, busy} after the edge
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] sb[$];
    int         n_vec = 0;
    int         n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One row per cycle; start/load are asserted only on the first row.
    task automatic seg(input logic r, input logic e, input logic m,
                       input logic s, input logic l,
                       input int unsigned p, input int unsigned w,
                       input string ep, input string et, input string eb);
        vec_t v;
        for (int i = 0; i < ep.len(); i++) begin
            v.rst_n = r;
            v.en    = e;
            v.mode  = m;
            v.start = (i == 0) ? s : 1'b0;
            v.load  = (i == 0) ? l : 1'b0;
            v.p     = 30'(p);
            v.w     = 30'(w);
            v.exp   = {ep.getc(i) == "1", et.getc(i) == "1", eb.getc(i) == "1"};
            vecs.push_back(v);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {pulse,tick,busy} got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        logic [2:0] exp;
        bit         got_tick;
        int         n;
        int         hi;

        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.mode      = 1'b0;
        bus.start     = 1'b0;
        bus.load      = 1'b0;
        bus.period_in = '0;
        bus.width_in  = '0;

        // Continuous with defaults, then a mid-period reload to 10/2
        seg(1,1,0,0,0, 0,0, "00000111000011", "00000100000010", "11111111111111");
        seg(1,1,0,0,0, 0,0, "10", "00", "11");
        seg(1,1,0,0,1, 10,2, "0", "0", "1");
        seg(1,1,0,0,0, 0,0, "0011100000000110000000011",
                            "0010000000000100000000010",
                            "1111111111111111111111111");
        // Clamping: 1/5 -> 2/1 alternation, then 8/0 never rises
        seg(1,0,0,0,1, 1,5, "0", "0", "0");
        seg(1,1,0,0,0, 0,0, "00101010", "00101010", "11111111");
        seg(1,0,0,0,1, 8,0, "0", "0", "0");
        seg(1,1,0,0,0, 0,0, "0000000000", "0000000000", "1111111111");
        // One-shot 6/2 with a retrigger attempt during the run
        seg(1,0,1,0,1, 6,2, "0", "0", "0");
        seg(1,1,1,0,0, 0,0, "0", "0", "0");
        seg(1,1,1,1,0, 0,0, "00", "00", "11");
        seg(1,1,1,1,0, 0,0, "00011000", "00010000", "11110000");
        // Start and load together in idle: run uses 4/1 immediately
        seg(1,1,1,1,1, 4,1, "000010", "000010", "111100");
        // en dropped at cnt=3, restart, reset mid-pulse, defaults restored
        seg(1,0,0,0,1, 5,2, "0", "0", "0");
        seg(1,1,0,0,0, 0,0, "0000", "0000", "1111");
        seg(1,0,0,0,0, 0,0, "0", "0", "0");
        seg(1,1,0,0,0, 0,0, "00001", "00001", "11111");
        seg(0,1,0,0,0, 0,0, "0", "0", "0");
        seg(1,1,0,0,0, 0,0, "00000111", "00000100", "11111111");

        repeat (2) @(posedge clk);
        #1;
        check3("reset_state", {bus.pulse, bus.tick, bus.busy}, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n         = vecs[i].rst_n;
            bus.en        = vecs[i].en;
            bus.mode      = vecs[i].mode;
            bus.start     = vecs[i].start;
            bus.load      = vecs[i].load;
            bus.period_in = vecs[i].p;
            bus.width_in  = vecs[i].w;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            check3($sformatf("vec%0d", i), {bus.pulse, bus.tick, bus.busy}, exp);
        end

        // Free-running defaults: tick spacing and high time over one period
        rst_n     = 1'b1;
        bus.en    = 1'b1;
        bus.mode  = 1'b0;
        bus.start = 1'b0;
        bus.load  = 1'b0;
        got_tick  = 1'b0;
        for (int c = 0; c < 20 && !got_tick; c++) begin
            @(posedge clk);
            #1;
            if (bus.tick) got_tick = 1'b1;
        end
        check_int("tick_seen", int'(got_tick), 1);
        n  = 0;
        hi = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (bus.pulse) hi++;
        end while (!bus.tick && n < 20);
        check_int("tick_interval", n, 7);
        check_int("pulse_high_cycles", hi, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
